// File: rtl/uart_rx_os.sv
// UART receiver: configurable frame format, 3-sample majority voting, false-start
// rejection, parity/framing/break/overrun detection and a one-entry valid/ready output.
module uart_rx_os #(
  parameter int BAUD_DIV    = 434,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BCNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] SAMP_A    = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] SAMP_B    = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] SAMP_C    = CW'(BAUD_DIV / 2 + 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [1:0]    PMODE     = 2'(PARITY_MODE);

  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, BRKWAIT = 3'd5
  } state_t;

  function automatic logic parity_fail(input logic [DATA_BITS-1:0] d, input logic p,
                                       input logic [1:0] mode);
    logic x;
    x = ^{d, p};
    case (mode)
      2'd1:    parity_fail = x;
      2'd2:    parity_fail = ~x;
      default: parity_fail = 1'b0;
    endcase
  endfunction

  state_t                 state_r, state_nx_s;
  logic                   rx_meta_r, rx_s_r, rx_prev_r;
  logic [CW-1:0]          bcnt_r;
  logic [3:0]             bidx_r;
  logic [1:0]             samp_r;
  logic [DATA_BITS-1:0]   shreg_r, frm_data_r, data_out_r;
  logic                   perr_r, ferr_r, zero_r;
  logic                   done_r, frm_perr_r, frm_ferr_r, break_r;
  logic                   valid_r, parity_err_r, frame_err_r, overrun_r, busy_r;
  logic                   fall_s, wrap_s, res_s, maj_s, ferr_now_s, brk_now_s, complete_s;

  assign fall_s     = rx_prev_r & ~rx_s_r;
  assign wrap_s     = (bcnt_r == BCNT_LAST);
  assign res_s      = (bcnt_r == SAMP_C);
  assign maj_s      = (samp_r[0] & samp_r[1]) | (samp_r[0] & rx_s_r) | (samp_r[1] & rx_s_r);
  assign ferr_now_s = ferr_r | ~maj_s;
  // zero_r already covers the first stop bit once a second stop bit is being resolved
  assign brk_now_s  = zero_r & ((bidx_r == 4'd0) ? ~maj_s : 1'b1);

  // Next-state decode and frame-completion strobe
  always_comb begin
    state_nx_s = state_r;
    complete_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s) state_nx_s = START;
        else        state_nx_s = IDLE;
      end
      START: begin
        if (res_s && maj_s) state_nx_s = IDLE;
        else if (wrap_s)    state_nx_s = DATA;
        else                state_nx_s = START;
      end
      DATA: begin
        if (wrap_s && (bidx_r == LAST_DATA)) state_nx_s = (PMODE != 2'd0) ? PARITY : STOP;
        else                                 state_nx_s = DATA;
      end
      PARITY: begin
        if (wrap_s) state_nx_s = STOP;
        else        state_nx_s = PARITY;
      end
      STOP: begin
        if (res_s && (bidx_r == LAST_STOP)) begin
          complete_s = 1'b1;
          state_nx_s = brk_now_s ? BRKWAIT : IDLE;
        end else begin
          state_nx_s = STOP;
        end
      end
      BRKWAIT: begin
        if (rx_s_r) state_nx_s = IDLE;
        else        state_nx_s = BRKWAIT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Synchroniser, state register, bit timer and frame datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r  <= 1'b1;
      rx_s_r     <= 1'b1;
      rx_prev_r  <= 1'b1;
      state_r    <= IDLE;
      bcnt_r     <= {CW{1'b0}};
      bidx_r     <= 4'd0;
      samp_r     <= 2'b11;
      shreg_r    <= {DATA_BITS{1'b0}};
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      zero_r     <= 1'b1;
      done_r     <= 1'b0;
      break_r    <= 1'b0;
      frm_data_r <= {DATA_BITS{1'b0}};
      frm_perr_r <= 1'b0;
      frm_ferr_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      rx_meta_r <= rx;
      rx_s_r    <= rx_meta_r;
      rx_prev_r <= rx_s_r;
      state_r   <= state_nx_s;
      busy_r    <= (state_nx_s != IDLE);
      if (state_r == IDLE || wrap_s) bcnt_r <= {CW{1'b0}};
      else                           bcnt_r <= bcnt_r + CW'(1);
      if (state_nx_s != state_r) bidx_r <= 4'd0;
      else if (wrap_s)           bidx_r <= bidx_r + 4'd1;
      if (bcnt_r == SAMP_A) samp_r[0] <= rx_s_r;
      if (bcnt_r == SAMP_B) samp_r[1] <= rx_s_r;
      case (state_r)
        IDLE: begin
          perr_r <= 1'b0;
          ferr_r <= 1'b0;
          zero_r <= 1'b1;
        end
        DATA: if (res_s) begin
          shreg_r <= {maj_s, shreg_r[DATA_BITS-1:1]};
          zero_r  <= zero_r & ~maj_s;
        end
        PARITY: if (res_s) begin
          perr_r <= parity_fail(shreg_r, maj_s, PMODE);
          zero_r <= zero_r & ~maj_s;
        end
        STOP: if (res_s) begin
          ferr_r <= ferr_now_s;
          if (bidx_r == 4'd0) zero_r <= zero_r & ~maj_s;
        end
        default: ;
      endcase
      done_r  <= complete_s;
      break_r <= complete_s & brk_now_s;
      if (complete_s) begin
        frm_data_r <= brk_now_s ? {DATA_BITS{1'b0}} : shreg_r;
        frm_perr_r <= perr_r & ~brk_now_s;
        frm_ferr_r <= ferr_now_s;
      end
    end
  end

  // Holding register with valid/ready handshake and overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r   <= {DATA_BITS{1'b0}};
      valid_r      <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (done_r) begin
      if (!valid_r || ready) begin
        data_out_r   <= frm_data_r;
        parity_err_r <= frm_perr_r;
        frame_err_r  <= frm_ferr_r;
        valid_r      <= 1'b1;
        overrun_r    <= 1'b0;
      end else begin
        overrun_r <= 1'b1;
      end
    end else begin
      overrun_r <= 1'b0;
      if (valid_r && ready) valid_r <= 1'b0;
    end
  end

  assign data_out   = data_out_r;
  assign valid      = valid_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign break_det  = break_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;
endmodule
